mux_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 31:1 x 2-bit select mux between 31 requesters.
- Arbitrates among pending requests and drives the mux select. Captures the selected mux output into a register and presents it downstream on a valid/ready handshake.
- Sits directly in front of the mux: `sel` drives the mux select, and `mux_out` returns the mux output.

---
 rtl/mux_sched_pkg.sv | 27 ++
 rtl/rr_pick.sv | 34 +++
 rtl/mux_rr_sched.sv | 114 +++++++++++
 tb/tb_mux_rr_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM state encoding and helpers for the round-robin
// scheduler that drives one shared 31:1 x 2-bit select mux.
//   N_REQ    : number of requesters (mux input count)
//   DW       : width of each mux input/output
//   SEL_W    : width of the mux select
//   IDLE_SEL : parked select value; the mux returns 0 for it
package mux_sched_pkg;

   localparam int N_REQ = 31;
   localparam int DW    = 2;
   localparam int SEL_W = 5;
   localparam logic [SEL_W-1:0] IDLE_SEL = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // One-hot grant vector for a requester index (index must be < N_REQ).
   function automatic logic [N_REQ-1:0] onehot_grant(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = {{(N_REQ-1){1'b0}}, 1'b1};
      return v << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority search over the request vector.
// Ports:
//   i_req   : per-requester request bits [30:0]
//   i_ptr   : last served index; search starts at i_ptr+1 and wraps 30->0
//   o_found : at least one request is set
//   o_idx   : winning requester index (0 when nothing is found)
module rr_pick
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic             o_found,
   output logic [SEL_W-1:0] o_idx
);

   // Bit 31 is padded to zero so the parked select can never win.
   logic [31:0] w_req_ext;
   assign w_req_ext = {1'b0, i_req};

   // Walk the 31 candidates in rotation order; the first set bit wins.
   always_comb begin
      logic [5:0] v_cand;
      o_found = 1'b0;
      o_idx   = 5'd0;
      v_cand  = 6'd0;
      for (int k = 0; k < N_REQ; k++) begin
         v_cand  = {1'b0, i_ptr} + 6'd1 + 6'(k);
         v_cand  = (v_cand >= 6'd31) ? (v_cand - 6'd31) : v_cand;
         o_idx   = (!o_found && w_req_ext[v_cand[4:0]]) ? v_cand[4:0] : o_idx;
         o_found = o_found | w_req_ext[v_cand[4:0]];
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler in front of a shared 31:1 x 2-bit select mux.
// Picks a requester, drives the mux select, captures the settled mux output
// and offers it downstream on a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_req       : per-requester level requests
//   o_grant     : one-hot single-cycle pulse when a requester's data is captured
//   o_sel       : registered mux select (IDLE_SEL when parked)
//   i_mux_out   : mux output, combinational from o_sel
//   o_out_data  : captured data
//   o_out_src   : requester index of o_out_data
//   o_out_valid : o_out_data/o_out_src valid
//   i_out_ready : downstream accepts
//   o_busy      : FSM not idle
module mux_rr_sched
   import mux_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_grant,
   output logic [SEL_W-1:0] o_sel,
   input  logic [DW-1:0]    i_mux_out,
   output logic [DW-1:0]    o_out_data,
   output logic [SEL_W-1:0] o_out_src,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy
);

   state_t           r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [DW-1:0]    r_out_data;
   logic [SEL_W-1:0] r_out_src;
   logic             r_out_valid;
   logic [N_REQ-1:0] r_grant;

   logic             w_found;
   logic [SEL_W-1:0] w_idx;
   logic [SEL_W-1:0] w_pick_ptr;

   // In HOLD the pick must already see the pointer advanced to out_src.
   assign w_pick_ptr = (r_state == ST_HOLD) ? r_out_src : r_ptr;

   rr_pick u_pick (
      .i_req   (i_req),
      .i_ptr   (w_pick_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 5'd30;
         r_sel       <= IDLE_SEL;
         r_out_data  <= {DW{1'b0}};
         r_out_src   <= IDLE_SEL;
         r_out_valid <= 1'b0;
         r_grant     <= {N_REQ{1'b0}};
      end else begin
         r_grant <= {N_REQ{1'b0}};
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_sel   <= w_idx;
                  r_state <= ST_SETTLE;
               end else begin
                  r_sel   <= IDLE_SEL;
                  r_state <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               // Capture is unconditional; the mux has had a full cycle to settle.
               r_out_data  <= i_mux_out;
               r_out_src   <= r_sel;
               r_out_valid <= 1'b1;
               r_grant     <= onehot_grant(r_sel);
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (r_out_valid && i_out_ready) begin
                  r_ptr       <= r_out_src;
                  r_out_valid <= 1'b0;
                  if (w_found) begin
                     r_sel   <= w_idx;
                     r_state <= ST_SETTLE;
                  end else begin
                     r_sel   <= IDLE_SEL;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_HOLD;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_sel       <= IDLE_SEL;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_sel       = r_sel;
   assign o_out_data  = r_out_data;
   assign o_out_src   = r_out_src;
   assign o_out_valid = r_out_valid;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed self-checking bench for mux_rr_sched. The mux is modelled as
// sel==31 -> 0, otherwise sel[1:0] ^ mux_xor.
module tb_mux_rr_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [30:0] req;
   logic [30:0] grant;
   logic [4:0]  sel;
   logic [1:0]  mux_out;
   logic [1:0]  out_data;
   logic [4:0]  out_src;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [1:0]  mux_xor;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mux_out = (sel == 5'd31) ? 2'b00 : (sel[1:0] ^ mux_xor);

   mux_rr_sched dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req),
      .o_grant     (grant),
      .o_sel       (sel),
      .i_mux_out   (mux_out),
      .o_out_data  (out_data),
      .o_out_src   (out_src),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int idx);
      logic [31:0] v;
      v = 32'd1;
      return v << idx;
   endfunction

   // Checks for the cycle in which a transfer from 'src' is presented.
   task automatic chk_xfer(input string tag, input int src, input logic [1:0] data);
      chk({tag, "_src"},   {27'd0, out_src}, 32'(src));
      chk({tag, "_data"},  {30'd0, out_data}, {30'd0, data});
      chk({tag, "_grant"}, {1'b0, grant}, oh(src));
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      int exp_src;
      rst = 1'b1; req = 31'd0; out_ready = 1'b0; mux_xor = 2'b00;
      tick(); tick();
      chk("rst_sel",   {27'd0, sel}, 32'd31);
      chk("rst_src",   {27'd0, out_src}, 32'd31);
      chk("rst_data",  {30'd0, out_data}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_grant", {1'b0, grant}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_sel",   {27'd0, sel}, 32'd31);
         chk("idle_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_grant", {1'b0, grant}, 32'd0);
         chk("idle_busy",  {31'd0, busy}, 32'd0);
      end

      // Single request from requester 5; mux returns 2'b10 for sel=5.
      mux_xor = 2'b11;
      req = 31'd1 << 5;
      tick();
      chk("single_sel",   {27'd0, sel}, 32'd5);
      chk("single_busy",  {31'd0, busy}, 32'd1);
      chk("single_v0",    {31'd0, out_valid}, 32'd0);
      chk("single_g0",    {1'b0, grant}, 32'd0);
      tick();
      chk_xfer("single", 5, 2'b10);
      req = 31'd0; out_ready = 1'b1;
      tick();
      chk("single_done_valid", {31'd0, out_valid}, 32'd0);
      chk("single_done_sel",   {27'd0, sel}, 32'd31);
      chk("single_done_grant", {1'b0, grant}, 32'd0);
      chk("single_done_busy",  {31'd0, busy}, 32'd0);
      out_ready = 1'b0;

      // All requesters active: rotation starts after last served (5).
      mux_xor = 2'b00;
      req = {31{1'b1}}; out_ready = 1'b1;
      exp_src = 6;
      for (int n = 0; n < 56; n++) begin
         tick();
         chk("rr_settle_sel",   {27'd0, sel}, 32'(exp_src));
         chk("rr_settle_valid", {31'd0, out_valid}, 32'd0);
         chk("rr_settle_grant", {1'b0, grant}, 32'd0);
         tick();
         chk_xfer("rr", exp_src, 2'(exp_src));
         exp_src = (exp_src == 30) ? 0 : exp_src + 1;
      end

      // Wrap: 30 just served; requests at 30 and 2 -> 2 then 30.
      req = (31'd1 << 30) | (31'd1 << 2);
      tick();
      chk("wrap_sel2", {27'd0, sel}, 32'd2);
      tick();
      chk_xfer("wrap2", 2, 2'd2);
      req = 31'd1 << 30;
      tick();
      chk("wrap_sel30", {27'd0, sel}, 32'd30);
      tick();
      chk_xfer("wrap30", 30, 2'd2);

      // Backpressure with 1, 4 and a still-requesting 30 pending.
      out_ready = 1'b0;
      req = (31'd1 << 30) | (31'd1 << 4) | (31'd1 << 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_src",   {27'd0, out_src}, 32'd30);
         chk("bp_data",  {30'd0, out_data}, 32'd2);
         chk("bp_sel",   {27'd0, sel}, 32'd30);
         chk("bp_grant", {1'b0, grant}, 32'd0);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_sel1",   {27'd0, sel}, 32'd1);
      chk("bp_valid0", {31'd0, out_valid}, 32'd0);
      tick();
      chk_xfer("bp1", 1, 2'd1);
      req = (31'd1 << 30) | (31'd1 << 4);
      tick();
      chk("bp_sel4", {27'd0, sel}, 32'd4);
      tick();
      chk_xfer("bp4", 4, 2'd0);
      req = 31'd1 << 30;
      tick();
      chk("bp_sel30", {27'd0, sel}, 32'd30);
      tick();
      chk_xfer("bp30", 30, 2'd2);
      req = 31'd0;
      tick();
      chk("bp_idle_sel",  {27'd0, sel}, 32'd31);
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);

      // Reset during SETTLE.
      out_ready = 1'b0;
      req = 31'd1 << 7;
      tick();
      chk("rs_settle_sel", {27'd0, sel}, 32'd7);
      rst = 1'b1; #1;
      chk("rs_settle_sel31", {27'd0, sel}, 32'd31);
      chk("rs_settle_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_settle_grant", {1'b0, grant}, 32'd0);
      chk("rs_settle_busy",  {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Reset during HOLD.
      tick();
      chk("rs_hold_sel", {27'd0, sel}, 32'd7);
      tick();
      chk_xfer("rs_hold", 7, 2'd3);
      rst = 1'b1; #1;
      chk("rs_hold_sel31", {27'd0, sel}, 32'd31);
      chk("rs_hold_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_hold_grant", {1'b0, grant}, 32'd0);
      chk("rs_hold_src",   {27'd0, out_src}, 32'd31);
      rst = 1'b0;

      // Pointer restarts at 30: requester 0 wins before 3.
      req = (31'd1 << 3) | 31'd1;
      out_ready = 1'b1;
      tick();
      chk("post_sel0", {27'd0, sel}, 32'd0);
      tick();
      chk_xfer("post0", 0, 2'd0);
      req = 31'd1 << 3;
      tick();
      chk("post_sel3", {27'd0, sel}, 32'd3);
      tick();
      chk_xfer("post3", 3, 2'd3);
      req = 31'd0;
      tick();
      chk("post_idle_sel",   {27'd0, sel}, 32'd31);
      chk("post_idle_valid", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
